// File: rtl/alu_control_pkg.sv
// ---------------------------------------------------------------------------
// alu_control_pkg
// Shared definitions for the WISC-SP13 ALU control decoder:
//   - opcode localparams for all 32 instruction opcodes (instr[15:11])
//   - R-format funct localparams (instr[1:0])
//   - 3-bit aluOp encodings ALU_ROL .. ALU_AND
//   - ctrl_t bundle of the five ALU control outputs and helper functions
// ---------------------------------------------------------------------------
package alu_control_pkg;

   // Opcodes
   localparam logic [4:0] OP_HALT    = 5'b00000;
   localparam logic [4:0] OP_NOP     = 5'b00001;
   localparam logic [4:0] OP_SIIC    = 5'b00010;
   localparam logic [4:0] OP_RTI     = 5'b00011;
   localparam logic [4:0] OP_J       = 5'b00100;
   localparam logic [4:0] OP_JR      = 5'b00101;
   localparam logic [4:0] OP_JAL     = 5'b00110;
   localparam logic [4:0] OP_JALR    = 5'b00111;
   localparam logic [4:0] OP_ADDI    = 5'b01000;
   localparam logic [4:0] OP_SUBI    = 5'b01001;
   localparam logic [4:0] OP_XORI    = 5'b01010;
   localparam logic [4:0] OP_ANDNI   = 5'b01011;
   localparam logic [4:0] OP_BEQZ    = 5'b01100;
   localparam logic [4:0] OP_BNEZ    = 5'b01101;
   localparam logic [4:0] OP_BLTZ    = 5'b01110;
   localparam logic [4:0] OP_BGEZ    = 5'b01111;
   localparam logic [4:0] OP_ST      = 5'b10000;
   localparam logic [4:0] OP_LD      = 5'b10001;
   localparam logic [4:0] OP_SLBI    = 5'b10010;
   localparam logic [4:0] OP_STU     = 5'b10011;
   localparam logic [4:0] OP_ROLI    = 5'b10100;
   localparam logic [4:0] OP_SLLI    = 5'b10101;
   localparam logic [4:0] OP_RORI    = 5'b10110;
   localparam logic [4:0] OP_SRLI    = 5'b10111;
   localparam logic [4:0] OP_LBI     = 5'b11000;
   localparam logic [4:0] OP_BTR     = 5'b11001;
   localparam logic [4:0] OP_SHIFT_R = 5'b11010;
   localparam logic [4:0] OP_ARITH_R = 5'b11011;
   localparam logic [4:0] OP_SEQ     = 5'b11100;
   localparam logic [4:0] OP_SLT     = 5'b11101;
   localparam logic [4:0] OP_SLE     = 5'b11110;
   localparam logic [4:0] OP_SCO     = 5'b11111;

   // R-format funct values (arithmetic group, opcode 11011)
   localparam logic [1:0] FN_ADD  = 2'b00;
   localparam logic [1:0] FN_SUB  = 2'b01;
   localparam logic [1:0] FN_XOR  = 2'b10;
   localparam logic [1:0] FN_ANDN = 2'b11;
   // R-format funct values (shift group, opcode 11010)
   localparam logic [1:0] FN_ROL  = 2'b00;
   localparam logic [1:0] FN_SLL  = 2'b01;
   localparam logic [1:0] FN_ROR  = 2'b10;
   localparam logic [1:0] FN_SRL  = 2'b11;

   // ALU operation select
   localparam logic [2:0] ALU_ROL = 3'b000;
   localparam logic [2:0] ALU_SLL = 3'b001;
   localparam logic [2:0] ALU_ROR = 3'b010;
   localparam logic [2:0] ALU_SRL = 3'b011;
   localparam logic [2:0] ALU_ADD = 3'b100;
   localparam logic [2:0] ALU_OR  = 3'b101;
   localparam logic [2:0] ALU_XOR = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b111;

   typedef struct packed {
      logic [2:0] aluOp;
      logic       invA;
      logic       invB;
      logic       Cin;
      logic       sign;
   } ctrl_t;

   function automatic ctrl_t mk_ctrl(input logic [2:0] op, input logic ia,
                                     input logic ib, input logic c, input logic s);
      ctrl_t r;
      r.aluOp = op;
      r.invA  = ia;
      r.invB  = ib;
      r.Cin   = c;
      r.sign  = s;
      return r;
   endfunction

   // The register and immediate arithmetic forms share one 2-bit selector:
   // funct for 11011, opcode[1:0] for 01000..01011 (same ordering).
   function automatic ctrl_t arith_ctrl(input logic [1:0] sel);
      ctrl_t r;
      case (sel)
         FN_ADD:  r = mk_ctrl(ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b1);
         FN_SUB:  r = mk_ctrl(ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b1); // B - A = ~A + B + 1
         FN_XOR:  r = mk_ctrl(ALU_XOR, 1'b0, 1'b0, 1'b0, 1'b0);
         default: r = mk_ctrl(ALU_AND, 1'b0, 1'b1, 1'b0, 1'b0); // ANDN = A & ~B
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_control_if.sv
// ---------------------------------------------------------------------------
// alu_control_if
// Bundles the decoder inputs (opCode, funct) and the ALU control outputs
// (aluOp, invA, invB, Cin, sign).
//   master : instruction decode side, drives opCode/funct
//   slave  : alu_control, drives the ALU controls
// ---------------------------------------------------------------------------
interface alu_control_if;
   logic [4:0] opCode;
   logic [1:0] funct;
   logic [2:0] aluOp;
   logic       invA;
   logic       invB;
   logic       Cin;
   logic       sign;

   modport master (output opCode, funct,
                   input  aluOp, invA, invB, Cin, sign);
   modport slave  (input  opCode, funct,
                   output aluOp, invA, invB, Cin, sign);
endinterface

// File: rtl/alu_control_decode.sv
// ---------------------------------------------------------------------------
// alu_control_decode
// Purely combinational opcode/funct -> ALU control decoder.
//   opCode in  5  instruction bits [15:11]
//   funct  in  2  instruction bits [1:0] (used only by 11011 and 11010)
//   ctrl   out    {aluOp, invA, invB, Cin, sign}
// ---------------------------------------------------------------------------
module alu_control_decode
   import alu_control_pkg::*;
(
   input  logic [4:0] opCode,
   input  logic [1:0] funct,
   output ctrl_t      ctrl
);

   always_comb begin
      // Default covers HALT, NOP, SIIC, RTI and the jump family.
      ctrl = mk_ctrl(ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
      case (opCode)
         OP_ARITH_R:                         ctrl = arith_ctrl(funct);
         OP_ADDI, OP_SUBI, OP_XORI, OP_ANDNI: ctrl = arith_ctrl(opCode[1:0]);
         // Shift funct and shift-immediate opcode[1:0] both follow the
         // ROL/SLL/ROR/SRL ordering of aluOp 000..011.
         OP_SHIFT_R:                         ctrl = mk_ctrl({1'b0, funct}, 1'b0, 1'b0, 1'b0, 1'b0);
         OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI: ctrl = mk_ctrl({1'b0, opCode[1:0]}, 1'b0, 1'b0, 1'b0, 1'b0);
         OP_ST, OP_LD, OP_STU:               ctrl = mk_ctrl(ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b1);
         OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ: ctrl = mk_ctrl(ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b1);
         // Set-on-compare computes A - B = A + ~B + 1.
         OP_SEQ, OP_SLT, OP_SLE:             ctrl = mk_ctrl(ALU_ADD, 1'b0, 1'b1, 1'b1, 1'b1);
         OP_SCO:                             ctrl = mk_ctrl(ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
         OP_BTR, OP_LBI, OP_SLBI:            ctrl = mk_ctrl(ALU_OR,  1'b0, 1'b0, 1'b0, 1'b0);
         default:                            ctrl = mk_ctrl(ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
      endcase
   end

endmodule

// File: rtl/alu_control.sv
// ---------------------------------------------------------------------------
// alu_control
// WISC-SP13 ALU control decoder top level.
//   clk    in  system clock (registered build only)
//   rst_n  in  asynchronous active-low reset (registered build only)
//   bus    alu_control_if.slave: opCode/funct in, aluOp/invA/invB/Cin/sign out
// Build option ALU_CONTROL_REG_OUT_EN:
//   defined   - outputs registered on rising clk, cleared to zero while rst_n=0
//   undefined - outputs combinational from opCode/funct; clk/rst_n unused
// ---------------------------------------------------------------------------
module alu_control
   import alu_control_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   alu_control_if.slave bus
);

   ctrl_t dec_ctrl;
   ctrl_t out_ctrl;

   alu_control_decode u_decode (
      .opCode (bus.opCode),
      .funct  (bus.funct),
      .ctrl   (dec_ctrl)
   );

`ifdef ALU_CONTROL_REG_OUT_EN
   ctrl_t ctrl_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_reg <= '0;
      end else begin
         ctrl_reg <= dec_ctrl;
      end
   end

   assign out_ctrl = ctrl_reg;
`else
   // clk and rst_n are kept on the port list so both builds share one
   // interface; they are intentionally unused here.
   logic unused_clkrst;
   assign unused_clkrst = &{1'b0, clk, rst_n};
   assign out_ctrl      = dec_ctrl;
`endif

   assign bus.aluOp = out_ctrl.aluOp;
   assign bus.invA  = out_ctrl.invA;
   assign bus.invB  = out_ctrl.invB;
   assign bus.Cin   = out_ctrl.Cin;
   assign bus.sign  = out_ctrl.sign;

endmodule

// File: tb/tb_alu_control.sv
// ---------------------------------------------------------------------------
// tb_alu_control
// Self-checking bench for alu_control. Expected controls come from a
// rule-based reference model over integer opcode ranges. Outputs are
// sampled 1 time unit after the rising edge that follows each input change,
// which is valid for both the registered and combinational builds.
// ---------------------------------------------------------------------------
module tb_alu_control;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   alu_control_if bus ();

   alu_control dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: {aluOp[2:0], invA, invB, Cin, sign}
   function automatic logic [6:0] ref_ctrl(input int op, input int fn);
      logic [2:0] alu;
      logic ia, ib, c, s;
      int   kind;
      alu = 3'd4; ia = 1'b0; ib = 1'b0; c = 1'b0; s = 1'b0;
      if (op == 27 || (op >= 8 && op <= 11)) begin
         kind = (op == 27) ? fn : op - 8;
         if (kind == 0)      s = 1'b1;
         else if (kind == 1) begin ia = 1'b1; c = 1'b1; s = 1'b1; end
         else if (kind == 2) alu = 3'd6;
         else                begin alu = 3'd7; ib = 1'b1; end
      end else if (op == 26) begin
         alu = 3'(fn);
      end else if (op >= 20 && op <= 23) begin
         alu = 3'(op - 20);
      end else if (op == 16 || op == 17 || op == 19 || (op >= 12 && op <= 15)) begin
         s = 1'b1;
      end else if (op >= 28 && op <= 30) begin
         ib = 1'b1; c = 1'b1; s = 1'b1;
      end else if (op == 18 || op == 24 || op == 25) begin
         alu = 3'd5;
      end
      return {alu, ia, ib, c, s};
   endfunction

   function automatic logic [6:0] observed();
      return {bus.aluOp, bus.invA, bus.invB, bus.Cin, bus.sign};
   endfunction

   task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=%b required=%b", tag, obs, exp_v);
      end
   endtask

   // Apply one instruction, wait for the next rising edge, sample at +1.
   task automatic step(input logic [4:0] op, input logic [1:0] fn, input string tag);
      bus.opCode = op;
      bus.funct  = fn;
      @(posedge clk);
      #1;
      $display("op=%b fn=%b -> ctrl=%b (%s)", op, fn, observed(), tag);
      check(tag, observed(), ref_ctrl(int'(op), int'(fn)));
   endtask

   initial begin
      logic [6:0] rst_exp;
      logic [4:0] rop;
      logic [1:0] rfn;
      checks = 0;
      errors = 0;

      // Reset with an instruction applied
      rst_n      = 1'b0;
      bus.opCode = 5'b11011;
      bus.funct  = 2'b01;
`ifdef ALU_CONTROL_REG_OUT_EN
      rst_exp = 7'b0000000;
`else
      rst_exp = ref_ctrl(27, 1);
`endif
      @(posedge clk);
      #1;
      $display("reset: ctrl=%b", observed());
      check("reset", observed(), rst_exp);
      rst_n = 1'b1;

      // Directed steps
      step(5'b11011, 2'b00, "add");
      check("add_const", observed(), 7'b100_0001);
      step(5'b11011, 2'b01, "sub");
      check("sub_const", observed(), 7'b100_1011);
      step(5'b11010, 2'b00, "rol");
      step(5'b11010, 2'b01, "sll");
      step(5'b11010, 2'b10, "ror");
      step(5'b11010, 2'b11, "srl");
      check("srl_const", observed(), 7'b011_0000);
      step(5'b10110, 2'b11, "rori");
      check("rori_const", observed(), 7'b010_0000);
      step(5'b11101, 2'b00, "slt");
      check("slt_const", observed(), 7'b100_0111);
      step(5'b11111, 2'b10, "sco");
      check("sco_const", observed(), 7'b100_0000);
      step(5'b01011, 2'b00, "andni_f00");
      check("andni_f00_const", observed(), 7'b111_0100);
      step(5'b01011, 2'b11, "andni_f11");
      check("andni_f11_const", observed(), 7'b111_0100);
      step(5'b00000, 2'b00, "halt");
      check("halt_const", observed(), 7'b100_0000);

      // Full sweep of all opcode/funct combinations
      for (int op = 0; op < 32; op++) begin
         for (int fn = 0; fn < 4; fn++) begin
            step(5'(op), 2'(fn), $sformatf("sweep_%0d_%0d", op, fn));
         end
      end

      // Randomized instruction stream
      for (int i = 0; i < 100; i++) begin
         rop = 5'($urandom_range(31, 0));
         rfn = 2'($urandom_range(3, 0));
         step(rop, rfn, $sformatf("rand_%0d", i));
      end

      // Reset asserted mid-run: registered build clears immediately
      bus.opCode = 5'b11001;
      bus.funct  = 2'b00;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
`ifdef ALU_CONTROL_REG_OUT_EN
      rst_exp = 7'b0000000;
`else
      rst_exp = ref_ctrl(25, 0);
`endif
      $display("async reset: ctrl=%b", observed());
      check("async_reset", observed(), rst_exp);
      #2;
      rst_n = 1'b1;
      step(5'b11000, 2'b10, "lbi_after_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
